// File: rtl/tilt_cursor_pkg.sv
// Shared widths, FSM states and default tuning constants for the tilt cursor.
package tilt_cursor_pkg;

  localparam int TILT_W = 10;
  localparam int POS_W  = 8;

  localparam int X_MAX_DEF       = 159;
  localparam int Y_MAX_DEF       = 119;
  localparam int DEADZONE_DEF    = 16;
  localparam int FAST_THRESH_DEF = 96;
  localparam int STEP_DIV_DEF    = 2500000;
  localparam int STALE_TICKS_DEF = 8;

  typedef enum logic [1:0] {
    S_INIT,
    S_TRACK,
    S_STALE
  } state_e;

  // Centre coordinate of an axis whose largest position is max.
  function automatic logic [POS_W-1:0] center_of(input int max);
    return POS_W'((max + 1) / 2);
  endfunction

endpackage

// File: rtl/tilt_cursor_if.sv
// Accelerometer sample handshake plus cursor position outputs.
interface tilt_cursor_if;
  import tilt_cursor_pkg::*;

  logic [TILT_W-1:0] acl_x;
  logic [TILT_W-1:0] acl_y;
  logic              acl_valid;
  logic              center;
  logic              acl_read;
  logic [15:0]       xPos;
  logic [15:0]       yPos;
  logic              moving;

  modport master (
    output acl_x, acl_y, acl_valid, center,
    input  acl_read, xPos, yPos, moving
  );

  modport slave (
    input  acl_x, acl_y, acl_valid, center,
    output acl_read, xPos, yPos, moving
  );

endinterface

// File: rtl/tilt_axis_step.sv
// One axis of rate-based motion: tilt magnitude -> 0/1/2 pixel step, clamped to [0, MAX].
module tilt_axis_step
  import tilt_cursor_pkg::*;
#(
  parameter int MAX         = X_MAX_DEF,
  parameter int DEADZONE    = DEADZONE_DEF,
  parameter int FAST_THRESH = FAST_THRESH_DEF
) (
  input  logic signed [TILT_W-1:0] tilt,
  input  logic        [POS_W-1:0]  pos,
  input  logic                     en,
  output logic        [POS_W-1:0]  pos_next,
  output logic                     changed
);

  localparam int SUM_W = POS_W + 2;
  localparam logic signed [TILT_W:0]  DZ_S   = (TILT_W+1)'(DEADZONE);
  localparam logic signed [TILT_W:0]  FAST_S = (TILT_W+1)'(FAST_THRESH);
  localparam logic signed [SUM_W-1:0] MAX_S  = SUM_W'(MAX);

  logic signed [TILT_W:0]  tilt_ext;
  logic signed [TILT_W:0]  mag;
  logic signed [SUM_W-1:0] delta;
  logic signed [SUM_W-1:0] sum;

  always_comb begin
    // One extra bit so that the most negative tilt still has a positive magnitude.
    tilt_ext = {tilt[TILT_W-1], tilt};
    mag      = tilt_ext[TILT_W] ? -tilt_ext : tilt_ext;

    delta = '0;
    if (en && (mag > DZ_S)) begin
      delta = (mag >= FAST_S) ? SUM_W'(2) : SUM_W'(1);
      if (tilt[TILT_W-1]) delta = -delta;
    end

    sum = $signed({2'b00, pos}) + delta;
    if (sum[SUM_W-1])     pos_next = '0;
    else if (sum > MAX_S) pos_next = POS_W'(MAX);
    else                  pos_next = sum[POS_W-1:0];

    changed = (pos_next != pos);
  end

endmodule

// File: rtl/tilt_cursor.sv
// Tilt-to-cursor controller: sample capture, step timer, staleness FSM and
// registered position outputs for the 160x120 framebuffer.
//   state   | meaning
//   S_INIT  | no sample seen since reset; ticks do not move the cursor
//   S_TRACK | ticks apply the held sample's deltas and age the sample
//   S_STALE | held sample too old; ticks do not move the cursor
module tilt_cursor
  import tilt_cursor_pkg::*;
#(
  parameter int X_MAX       = X_MAX_DEF,
  parameter int Y_MAX       = Y_MAX_DEF,
  parameter int DEADZONE    = DEADZONE_DEF,
  parameter int FAST_THRESH = FAST_THRESH_DEF,
  parameter int STEP_DIV    = STEP_DIV_DEF,
  parameter int STALE_TICKS = STALE_TICKS_DEF
) (
  input  logic          clk,
  input  logic          rstBtn,
  tilt_cursor_if.slave  cur
);

  localparam int TMR_W = $clog2(STEP_DIV);
  localparam int STL_W = $clog2(STALE_TICKS + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STEP_DIV - 1);
  localparam logic [STL_W-1:0] STL_LAST = STL_W'(STALE_TICKS);
  localparam logic [POS_W-1:0] X_CTR    = center_of(X_MAX);
  localparam logic [POS_W-1:0] Y_CTR    = center_of(Y_MAX);

  state_e                     state_q, state_d;
  logic        [TMR_W-1:0]    tmr_q, tmr_d;
  logic        [STL_W-1:0]    stale_q, stale_d;
  logic signed [TILT_W-1:0]   held_x_q, held_x_d;
  logic signed [TILT_W-1:0]   held_y_q, held_y_d;
  logic        [POS_W-1:0]    xpos_q, xpos_d;
  logic        [POS_W-1:0]    ypos_q, ypos_d;
  logic                       moving_q, moving_d;
  logic                       acl_read_q, acl_read_d;

  logic             tick;
  logic             step_en;
  logic [POS_W-1:0] x_next, y_next;
  logic             x_chg, y_chg;

  assign tick    = (tmr_q == TMR_LAST);
  assign step_en = (state_q == S_TRACK);

  tilt_axis_step #(.MAX(X_MAX), .DEADZONE(DEADZONE), .FAST_THRESH(FAST_THRESH)) u_x_step (
    .tilt(held_x_q), .pos(xpos_q), .en(step_en), .pos_next(x_next), .changed(x_chg)
  );

  tilt_axis_step #(.MAX(Y_MAX), .DEADZONE(DEADZONE), .FAST_THRESH(FAST_THRESH)) u_y_step (
    .tilt(held_y_q), .pos(ypos_q), .en(step_en), .pos_next(y_next), .changed(y_chg)
  );

  always_comb begin
    state_d    = state_q;
    tmr_d      = tick ? '0 : tmr_q + 1'b1;
    stale_d    = stale_q;
    held_x_d   = held_x_q;
    held_y_d   = held_y_q;
    xpos_d     = xpos_q;
    ypos_d     = ypos_q;
    moving_d   = moving_q;
    acl_read_d = cur.acl_valid;

    if (cur.acl_valid) begin
      held_x_d = cur.acl_x;
      held_y_d = cur.acl_y;
      stale_d  = '0;
      state_d  = S_TRACK;
    end

    // Centering swallows a coincident tick entirely, including sample ageing.
    if (cur.center) begin
      tmr_d  = '0;
      xpos_d = X_CTR;
      ypos_d = Y_CTR;
    end else if (tick) begin
      xpos_d   = x_next;
      ypos_d   = y_next;
      moving_d = x_chg | y_chg;
      if ((state_q == S_TRACK) && !cur.acl_valid) begin
        stale_d = stale_q + 1'b1;
        if (stale_d == STL_LAST) state_d = S_STALE;
      end
    end
  end

  always_ff @(posedge clk or posedge rstBtn) begin
    if (rstBtn) begin
      state_q    <= S_INIT;
      tmr_q      <= '0;
      stale_q    <= '0;
      held_x_q   <= '0;
      held_y_q   <= '0;
      xpos_q     <= X_CTR;
      ypos_q     <= Y_CTR;
      moving_q   <= 1'b0;
      acl_read_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      stale_q    <= stale_d;
      held_x_q   <= held_x_d;
      held_y_q   <= held_y_d;
      xpos_q     <= xpos_d;
      ypos_q     <= ypos_d;
      moving_q   <= moving_d;
      acl_read_q <= acl_read_d;
    end
  end

  assign cur.acl_read = acl_read_q;
  assign cur.xPos     = {8'h00, xpos_q};
  assign cur.yPos     = {8'h00, ypos_q};
  assign cur.moving   = moving_q;

endmodule

// File: tb/tb_tilt_cursor.sv
// Scoreboard bench for tilt_cursor with STEP_DIV=4, STALE_TICKS=3.
module tb_tilt_cursor;

  typedef struct {
    int unsigned at;
    string       name;
    logic [15:0] x;
    logic [15:0] y;
    logic        mv;
    logic        rd;
  } exp_t;

  logic        clk;
  logic        rstBtn;
  int unsigned cyc = 0;
  int          ph;
  logic        last_v;
  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        sb[$];

  tilt_cursor_if cur();

  tilt_cursor #(.STEP_DIV(4), .STALE_TICKS(3)) dut (
    .clk(clk), .rstBtn(rstBtn), .cur(cur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: compare every expectation that falls due in the cycle just ended.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      n_tests++;
      if (cur.xPos !== e.x || cur.yPos !== e.y || cur.moving !== e.mv || cur.acl_read !== e.rd) begin
        n_fail++;
        $display("FAIL %s: got x=%0d y=%0d moving=%0b acl_read=%0b, want x=%0d y=%0d moving=%0b acl_read=%0b",
                 e.name, cur.xPos, cur.yPos, cur.moving, cur.acl_read, e.x, e.y, e.mv, e.rd);
      end
    end
  end

  // Drives one cycle; ph is the DUT step-timer value during that cycle (tick when 3).
  task automatic drive(input logic v, input logic [9:0] ax, input logic [9:0] ay, input logic c);
    @(negedge clk);
    cur.acl_valid = v;
    cur.acl_x     = ax;
    cur.acl_y     = ay;
    cur.center    = c;
    last_v        = v;
    ph            = (c || ph == 3) ? 0 : ph + 1;
  endtask

  task automatic wait_tick();
    while (ph != 3) drive(1'b0, 10'd0, 10'd0, 1'b0);
  endtask

  task automatic push(input int unsigned at, input string nm, input int x, input int y,
                      input logic mv, input logic rd);
    exp_t e;
    e.at = at; e.name = nm; e.x = 16'(x); e.y = 16'(y); e.mv = mv; e.rd = rd;
    sb.push_back(e);
  endtask

  task automatic exp_next(input string nm, input int x, input int y, input logic mv);
    push(cyc + 1, nm, x, y, mv, last_v);
  endtask

  initial begin
    int ex, ey;
    rstBtn = 1'b1;
    cur.acl_valid = 1'b0; cur.acl_x = '0; cur.acl_y = '0; cur.center = 1'b0;
    ph = 0; last_v = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    rstBtn = 1'b0; ph = 1;
    exp_next("reset", 80, 60, 1'b0);

    wait_tick(); drive(0, 10'd0, 10'd0, 0); exp_next("init_tick", 80, 60, 1'b0);

    drive(1, 10'd50, 10'(-200), 0);  exp_next("strobe_ack", 80, 60, 1'b0);
    drive(0, 10'd0, 10'd0, 0);       exp_next("ack_one_cycle", 80, 60, 1'b0);
    wait_tick(); drive(0, 10'd0, 10'd0, 0); exp_next("rate_slow_fast", 81, 58, 1'b1);

    drive(1, 10'd16, 10'd0, 0);
    wait_tick(); drive(0, 10'd0, 10'd0, 0); exp_next("deadzone", 81, 58, 1'b0);

    drive(1, 10'd96, 10'(-95), 0);
    wait_tick(); drive(0, 10'd0, 10'd0, 0); exp_next("fast_boundary", 83, 57, 1'b1);

    drive(1, 10'(-20), 10'd17, 0);
    wait_tick(); drive(1, 10'(-100), 10'd0, 0); exp_next("tick_old_sample", 82, 58, 1'b1);
    wait_tick(); drive(0, 10'd0, 10'd0, 0);     exp_next("tick_new_sample", 80, 58, 1'b1);

    drive(1, 10'(-100), 10'd0, 0);
    wait_tick(); drive(0, 10'd0, 10'd0, 1); exp_next("center_on_tick", 80, 60, 1'b1);
    drive(0, 10'd0, 10'd0, 0);
    drive(0, 10'd0, 10'd0, 1);              exp_next("center_mid", 80, 60, 1'b1);
    wait_tick(); drive(0, 10'd0, 10'd0, 0); exp_next("after_center", 78, 60, 1'b1);

    drive(1, 10'd100, 10'd0, 0);
    wait_tick(); drive(0, 10'd0, 10'd0, 0); exp_next("stale_t1", 80, 60, 1'b1);
    wait_tick(); drive(0, 10'd0, 10'd0, 0); exp_next("stale_t2", 82, 60, 1'b1);
    wait_tick(); drive(0, 10'd0, 10'd0, 0); exp_next("stale_t3", 84, 60, 1'b1);
    wait_tick(); drive(0, 10'd0, 10'd0, 0); exp_next("stale_hold1", 84, 60, 1'b0);
    wait_tick(); drive(0, 10'd0, 10'd0, 0); exp_next("stale_hold2", 84, 60, 1'b0);
    drive(1, 10'd100, 10'd0, 0);
    wait_tick(); drive(0, 10'd0, 10'd0, 0); exp_next("stale_resume", 86, 60, 1'b1);

    for (int k = 1; k <= 40; k++) begin
      ex = 86 + 2 * k; if (ex > 159) ex = 159;
      ey = 60 - 2 * k; if (ey < 0)   ey = 0;
      drive(1, 10'h1FF, 10'h200, 0);
      wait_tick(); drive(0, 10'd0, 10'd0, 0); exp_next("saturate", ex, ey, (k <= 37));
    end

    drive(1, 10'(-300), 10'd300, 0);
    wait_tick(); drive(0, 10'd0, 10'd0, 0);
    drive(0, 10'd0, 10'd0, 0); exp_next("pre_reset", 157, 2, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #2;
    rstBtn = 1'b1;
    push(cyc, "async_reset", 80, 60, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rstBtn = 1'b0; ph = 1; last_v = 1'b0;
    exp_next("reset_release", 80, 60, 1'b0);
    wait_tick(); drive(0, 10'd0, 10'd0, 0); exp_next("init_after_reset", 80, 60, 1'b0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations still pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tilt_cursor.md
# tilt_cursor

Converts accelerometer tilt samples into a saturating on-screen cursor position for the 160x120 framebuffer. It sits between the accelerometer reader and the memory controller, in place of the rotary-encoder position inputs. It also returns a one-cycle read acknowledge to the accelerometer reader. Motion is rate-based: each step tick moves the cursor 0, 1 or 2 pixels per axis, depending on tilt magnitude.

## Interface
- X_MAX, 159: largest x position (inclusive)
- Y_MAX, 119: largest y position (inclusive)
- DEADZONE, 16: |tilt| <= DEADZONE gives no motion on that axis
- FAST_THRESH, 96: |tilt| >= FAST_THRESH gives a 2-pixel step; otherwise 1
- STEP_DIV, 2500000: clock cycles per step tick (>= 2)
- STALE_TICKS, 8: ticks with no new sample before motion stops
- clk  in  1  system clock
- rstBtn  in  1  reset, asynchronous, active-high
- acl_x  in  10  x tilt, two's complement
- acl_y  in  10  y tilt, two's complement
- acl_valid  in  1  one-cycle strobe, new acl_x/acl_y present
- center  in  1  snap cursor to centre (level, sampled each cycle)
- acl_read  out  1  one-cycle acknowledge of a consumed sample
- xPos  out  16  cursor x, bits [15:8] always 0
- yPos  out  16  cursor y, bits [15:8] always 0
- moving  out  1  last tick changed the position

## Operation
- **Reset values:** xPos = (X_MAX+1)/2 = 80; yPos = (Y_MAX+1)/2 = 60; acl_read = 0; moving = 0; step timer = 0; stale counter = 0; held sample = 0; state = S_INIT.
- **Sample capture:** on acl_valid, latch acl_x/acl_y into the held registers, clear the stale counter and pulse acl_read. This happens in every state.
- **Step timer:** counts 0..STEP_DIV-1 and wraps. tick = (timer == STEP_DIV-1).
- **Per-axis delta on tick:**
  - mag = |v|, computed at 11 bits so that -512 gives 512.
  - mag <= DEADZONE gives 0.
  - DEADZONE < mag < FAST_THRESH gives ±1.
  - mag >= FAST_THRESH gives ±2.
  - Sign follows v. Positive acl_x increases xPos; positive acl_y increases yPos.
- **Saturation:**
  - pos+delta is computed signed at 10 bits and clamped to [0, MAX].
  - A 2-step at pos = MAX-1 gives MAX. A -2 step at pos = 1 gives 0.
- **moving:** updated on every tick. It is 1 iff xPos or yPos changed on that tick.
- **FSM:**
  - S_INIT: waiting for the first sample. Ticks apply no motion; moving = 0. acl_valid goes to S_TRACK.
  - S_TRACK: ticks apply deltas from the held sample. Each tick without acl_valid in the same cycle increments the stale counter. When the counter reaches STALE_TICKS, go to S_STALE.
  - S_STALE: ticks apply no motion; moving = 0. acl_valid goes to S_TRACK.
- **center:**
  - Position goes to (80, 60) and the timer clears to 0. Stale counter, held sample and state are unchanged.
  - center has priority over a tick in the same cycle. moving is not updated in that cycle.
- **acl_valid and tick in the same cycle:** the tick uses the old held sample. The new sample is latched and the stale counter is cleared.
- **Reset mid-operation:** all registers return to reset values immediately, with no wait for a clock edge.

## Timing
- acl_valid high in cycle n: held sample and state are updated at the end of n. acl_read is high in cycle n+1 only.
- Back-to-back acl_valid strobes give back-to-back acl_read pulses.
- tick in cycle n: xPos, yPos and moving are updated at the end of n and are valid from n+1. Latency is 1 cycle.
- Ticks occur every STEP_DIV cycles. The first tick after reset or center is at cycle STEP_DIV-1.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- Package tilt_cursor_pkg holds:
  - the tilt width (10) and position width (8)
  - the state enum {S_INIT, S_TRACK, S_STALE}
  - default threshold constants
- Sub-module tilt_axis_step, instantiated once per axis with MAX as a parameter. It takes the held tilt, the current position and an enable. It returns the saturated next position and a changed flag. It is purely combinational.
- The top level holds the timer, stale counter, FSM, sample capture and output registers.

## Test plan
Use STEP_DIV = 4 and STALE_TICKS = 3 in simulation.
- **Reset and init:** assert rstBtn, then release it. Expect xPos = 80, yPos = 60, acl_read = 0. Ticks with no sample: position stays 80/60 and moving = 0.
- **Rates:**
  - acl_x = 50, acl_y = -200: after one tick, expect 81/58 with moving = 1 and acl_read pulsed one cycle after the strobe.
  - acl_x = 16: expect no x motion.
- **Saturation:** acl_x = 511 held with fresh samples. Expect xPos to climb to 159 and stick there, with moving = 0 once both axes are pinned. acl_y = -512 drives yPos to 0.
- **Stale:** one sample of acl_x = 100, then none. Expect exactly 3 ticks of +2 motion, then S_STALE with no motion. A new sample resumes motion.
- **Collisions:**
  - center in the same cycle as a tick: expect 80/60.
  - acl_valid in the same cycle as a tick: the tick uses the previous sample and the new sample is applied on the next tick.
- **Mid-run reset:** assert rstBtn asynchronously between clock edges while moving. Expect the outputs to hold reset values before the next edge.
